// File: rtl/keypad_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_matrix_scanner_if
// Brief    : Key event handshake bundle (valid/ready) from the keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_matrix_scanner_if #(
  parameter int CODE_W = 4
);
  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              evt_press;
  logic              evt_repeat;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_press,
    output evt_repeat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_press,
    input  evt_repeat,
    output evt_ready
  );
endinterface
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_matrix_scanner
// Brief    : Row-scanned keypad matrix with per-frame debounce and press/release
//            events; optional auto-repeat enabled by defining KEYPAD_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner #(
  parameter int ROWS                = 4,
  parameter int COLS                = 4,
  parameter int SETTLE_CYCLES       = 4,
  parameter int DEBOUNCE_FRAMES     = 3,
  parameter int REPEAT_DELAY_FRAMES = 32,
  parameter int REPEAT_RATE_FRAMES  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ROWS-1:0]        row_drive,
  input  logic [COLS-1:0]        col_sense,
  output logic [ROWS*COLS-1:0]   keys,
  keypad_matrix_scanner_if.master evt
);

  localparam int c_KEYS   = ROWS * COLS;
  localparam int c_CODE_W = (c_KEYS > 1) ? $clog2(c_KEYS) : 1;
  localparam int c_ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_SET_W  = $clog2(SETTLE_CYCLES);
  localparam int c_DB_W   = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

  localparam logic [c_ROW_W-1:0]  c_ROW_LAST = c_ROW_W'(ROWS - 1);
  localparam logic [c_SET_W-1:0]  c_SET_LAST = c_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [c_CODE_W-1:0] c_IDX_LAST = c_CODE_W'(c_KEYS - 1);

  localparam logic [1:0] c_ST_DRIVE  = 2'd0;
  localparam logic [1:0] c_ST_UPDATE = 2'd1;
  localparam logic [1:0] c_ST_EVENT  = 2'd2;

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic                      r_active;
  logic [c_ROW_W-1:0]        r_row;
  logic [c_SET_W-1:0]        r_settle;
  logic [COLS-1:0]           r_sync1;
  logic [COLS-1:0]           r_sync2;
  logic [ROWS-1:0][COLS-1:0] r_raw;
  logic [c_KEYS-1:0]         w_raw;
  logic [c_KEYS-1:0]         r_stable;
  logic [c_KEYS-1:0]         r_change;
  logic [c_DB_W-1:0]         r_cnt     [c_KEYS];
  logic [c_DB_W-1:0]         w_cnt_nxt [c_KEYS];
  logic [c_KEYS-1:0]         w_flip;
  logic [c_KEYS-1:0]         w_stable_nxt;
  logic [c_KEYS-1:0]         w_flag;
  logic [c_KEYS-1:0]         w_rep_flag;
  logic [c_CODE_W-1:0]       r_idx;
  logic                      w_scan_done;
  logic                      w_evt_valid;
  logic                      w_fire;

  assign w_raw       = r_raw;
  assign keys        = r_stable;
  assign w_flag      = r_change | w_rep_flag;
  assign w_scan_done = r_active && (r_state == c_ST_DRIVE) &&
                       (r_settle == c_SET_LAST) && (r_row == c_ROW_LAST);
  assign w_fire      = w_evt_valid && evt.evt_ready;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_DRIVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_DRIVE:  if (w_scan_done) w_state_nxt = c_ST_UPDATE;
      c_ST_UPDATE: w_state_nxt = c_ST_EVENT;
      c_ST_EVENT:  if (!w_flag[r_idx] && (r_idx == c_IDX_LAST)) w_state_nxt = c_ST_DRIVE;
      default:     w_state_nxt = c_ST_DRIVE;
    endcase
  end

  // ---------------- outputs ----------------
  // r_active keeps the rows released until the first clock after reset.
  always_comb begin
    row_drive = '1;
    for (int r = 0; r < ROWS; r++) begin
      row_drive[r] = !(r_active && (r_state == c_ST_DRIVE) && (r_row == c_ROW_W'(r)));
    end
    w_evt_valid    = (r_state == c_ST_EVENT) && w_flag[r_idx];
    evt.evt_valid  = w_evt_valid;
    evt.evt_code   = w_evt_valid ? r_idx : '0;
    evt.evt_press  = w_evt_valid && r_stable[r_idx];
    evt.evt_repeat = w_evt_valid && w_rep_flag[r_idx];
  end

  // ---------------- per-key debounce ----------------
  always_comb begin
    w_flip    = '0;
    w_cnt_nxt = '{default: '0};
    for (int k = 0; k < c_KEYS; k++) begin
      w_flip[k]    = (w_raw[k] != r_stable[k]) && (r_cnt[k] == c_DB_LAST);
      w_cnt_nxt[k] = ((w_raw[k] == r_stable[k]) || w_flip[k]) ? '0 : r_cnt[k] + 1'b1;
    end
    w_stable_nxt = r_stable ^ w_flip;
  end

  // ---------------- scan / debounce / event datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_row    <= '0;
      r_settle <= '0;
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_raw    <= '0;
      r_stable <= '0;
      r_change <= '0;
      r_idx    <= '0;
      for (int k = 0; k < c_KEYS; k++) r_cnt[k] <= '0;
    end else begin
      r_active <= 1'b1;
      r_sync1  <= col_sense;
      r_sync2  <= r_sync1;
      case (r_state)
        c_ST_DRIVE: begin
          if (r_active) begin
            if (r_settle == c_SET_LAST) begin
              r_settle     <= '0;
              r_raw[r_row] <= ~r_sync2;
              r_row        <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end
        end
        c_ST_UPDATE: begin
          r_stable <= w_stable_nxt;
          r_change <= w_flip;
          r_idx    <= '0;
          for (int k = 0; k < c_KEYS; k++) r_cnt[k] <= w_cnt_nxt[k];
        end
        c_ST_EVENT: begin
          // After a handshake the index is held one cycle so valid drops before moving on.
          if (w_fire) begin
            r_change[r_idx] <= 1'b0;
          end else if (!w_flag[r_idx]) begin
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int c_REP_W = $clog2(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES + 1);
  localparam logic [c_REP_W-1:0] c_REP_DELAY = c_REP_W'(REPEAT_DELAY_FRAMES);
  localparam logic [c_REP_W-1:0] c_REP_WRAP  = c_REP_W'(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES);

  logic [c_REP_W-1:0] r_rep_cnt;
  logic [c_REP_W-1:0] w_rep_cnt_inc;
  logic [c_KEYS-1:0]  r_rep_pend;

  assign w_rep_cnt_inc = r_rep_cnt + 1'b1;
  assign w_rep_flag    = r_rep_pend;

  // Single shared counter: only meaningful while exactly one key is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt  <= '0;
      r_rep_pend <= '0;
    end else if (r_state == c_ST_UPDATE) begin
      if ((|w_flip) || !$onehot(w_stable_nxt)) begin
        r_rep_cnt  <= '0;
        r_rep_pend <= '0;
      end else if (w_rep_cnt_inc == c_REP_DELAY) begin
        r_rep_cnt  <= w_rep_cnt_inc;
        r_rep_pend <= w_stable_nxt;
      end else if (w_rep_cnt_inc == c_REP_WRAP) begin
        r_rep_cnt  <= c_REP_DELAY;
        r_rep_pend <= w_stable_nxt;
      end else begin
        r_rep_cnt <= w_rep_cnt_inc;
      end
    end else if (w_fire) begin
      r_rep_pend[r_idx] <= 1'b0;
    end
  end
`else
  logic w_unused_repeat;
  assign w_rep_flag      = '0;
  assign w_unused_repeat = (REPEAT_DELAY_FRAMES > 0) ^ (REPEAT_RATE_FRAMES > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_matrix_scanner
// Brief    : Scoreboard bench for keypad_matrix_scanner (queue of expected events).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NK   = ROWS * COLS;
  localparam int CW   = 4;

  typedef struct {
    int code;
    int press;
    int rep;
    int gap;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ROWS-1:0] row_drive;
  logic [COLS-1:0] col_sense;
  logic [NK-1:0]   keys;
  logic [NK-1:0]   key_down = '0;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  frame_cnt = 0;
  int  last_ev_frame = 0;

  keypad_matrix_scanner_if #(.CODE_W(CW)) evt_if ();

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(4), .DEBOUNCE_FRAMES(3),
    .REPEAT_DELAY_FRAMES(32), .REPEAT_RATE_FRAMES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row_drive(row_drive),
    .col_sense(col_sense),
    .keys(keys),
    .evt(evt_if)
  );

  always #5 clk = ~clk;

  // A held key pulls its column low while its row is driven low.
  always_comb begin
    col_sense = '1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (key_down[r*COLS + c] && !row_drive[r]) col_sense[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  task automatic push_ev(input int code, input int press, input int rep, input int gap);
    ev_t e;
    e.code = code; e.press = press; e.rep = rep; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rd(input logic [3:0] v, input int budget, input string what);
    int k = 0;
    while (row_drive !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (row_drive !== v) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout, row_drive=%b expected %b", what, row_drive, v);
    end
  endtask

  task automatic frame_sync();
    wait_rd(4'b0111, 300, "sync_row3");
    wait_rd(4'b1111, 300, "sync_update");
  endtask

  task automatic drain(input int budget, input string what);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout, %0d expected events still pending", what, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input int budget, input string what);
    int k = 0;
    while (evt_if.evt_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (evt_if.evt_valid !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout, evt_valid=%b expected 1", what, evt_if.evt_valid);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 evt_if.evt_ready = v;
  endtask

  // Monitor: counts frames and scores every accepted event against the queue.
  initial begin
    logic [3:0] prev_rd;
    prev_rd = '1;
    forever begin
      @(negedge clk);
      if (prev_rd == 4'b0111 && row_drive == 4'b1111) frame_cnt++;
      prev_rd = row_drive;
      if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_event: got code %0d press %0d repeat %0d, expected no event",
                   evt_if.evt_code, evt_if.evt_press, evt_if.evt_repeat);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("evt_code", int'(evt_if.evt_code), e.code);
          check("evt_press", int'(evt_if.evt_press), e.press);
          check("evt_repeat", int'(evt_if.evt_repeat), e.rep);
          if (e.gap >= 0) check("repeat_gap_frames", frame_cnt - last_ev_frame, e.gap);
        end
        last_ev_frame = frame_cnt;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    evt_if.evt_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);

    // Reset state
    check("rst_row_drive", int'(row_drive), 'hF);
    check("rst_keys", int'(keys), 0);
    check("rst_evt_valid", int'(evt_if.evt_valid), 0);
    check("rst_evt_code", int'(evt_if.evt_code), 0);
    check("rst_evt_press", int'(evt_if.evt_press), 0);
    check("rst_evt_repeat", int'(evt_if.evt_repeat), 0);
    rst_n = 1'b1;

    // Idle scan: 4 rows x 4 cycles, then 17 cycles released, then row 0 again
    wait_rd(4'b1110, 20, "first_row");
    for (int k = 0; k < 34; k++) begin
      check("scan_row_drive", int'(row_drive),
            (k < 16) ? ((~(1 << (k / 4))) & 'hF) : ((k == 33) ? 'hE : 'hF));
      @(negedge clk);
    end
    check("idle_keys", int'(keys), 0);

    // Press and release key 6 (r1,c2)
    frame_sync();
    key_down[6] = 1'b1;
    push_ev(6, 1, 0, -1);
    drain(600, "press6");
    check("keys_after_press6", int'(keys), 'h0040);
    frame_sync();
    key_down[6] = 1'b0;
    push_ev(6, 0, 0, -1);
    drain(600, "release6");
    check("keys_after_release6", int'(keys), 0);

    // Key 9 bouncing every frame: no event, no stable change
    for (int i = 0; i < 20; i++) begin
      frame_sync();
      key_down[9] = ~key_down[9];
      check("bounce_keys9", int'(keys[9]), 0);
    end
    repeat (4) frame_sync();
    check("bounce_keys_final", int'(keys), 0);

    // Keys 1 and 14 in the same frame with consumer stalled
    set_ready(1'b0);
    frame_sync();
    key_down[1]  = 1'b1;
    key_down[14] = 1'b1;
    push_ev(1, 1, 0, -1);
    push_ev(14, 1, 0, -1);
    wait_valid(600, "stall_valid");
    for (int k = 0; k < 10; k++) begin
      check("stall_hold_valid_code_press_rows",
            int'({evt_if.evt_valid, evt_if.evt_code, evt_if.evt_press, row_drive}),
            int'({1'b1, 4'd1, 1'b1, 4'hF}));
      @(negedge clk);
    end
    set_ready(1'b1);
    drain(200, "stall_drain");
    check("keys_1_14", int'(keys), 'h4002);
    frame_sync();
    key_down[1]  = 1'b0;
    key_down[14] = 1'b0;
    push_ev(1, 0, 0, -1);
    push_ev(14, 0, 0, -1);
    drain(600, "release_1_14");
    check("keys_after_release_1_14", int'(keys), 0);

    // Asynchronous reset while an event is pending
    set_ready(1'b0);
    frame_sync();
    key_down[3] = 1'b1;
    wait_valid(600, "pre_reset_valid");
    check("pre_reset_code", int'(evt_if.evt_code), 3);
    check("pre_reset_keys", int'(keys), 'h0008);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(evt_if.evt_valid), 0);
    check("async_rst_keys", int'(keys), 0);
    check("async_rst_row_drive", int'(row_drive), 'hF);
    key_down[3] = 1'b0;
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    set_ready(1'b1);
    nz = 0;
    while (row_drive == 4'b1111 && nz < 20) begin
      @(negedge clk);
      nz++;
    end
    check("resume_row0", int'(row_drive), 'hE);
    tick(33 * 4);
    check("post_reset_keys", int'(keys), 0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat on a single held key, stopped by a second key
    frame_sync();
    key_down[5] = 1'b1;
    push_ev(5, 1, 0, -1);
    push_ev(5, 1, 1, 32);
    push_ev(5, 1, 1, 8);
    push_ev(5, 1, 1, 8);
    drain(4000, "repeat5");
    frame_sync();
    key_down[10] = 1'b1;
    push_ev(10, 1, 0, -1);
    drain(600, "press10");
    tick(33 * 25);
    check("keys_5_10", int'(keys), 'h0420);
    frame_sync();
    key_down[5]  = 1'b0;
    key_down[10] = 1'b0;
    push_ev(5, 0, 0, -1);
    push_ev(10, 0, 0, -1);
    drain(600, "release_5_10");
`else
    // Held key without repeat support: a single press event only
    frame_sync();
    key_down[5] = 1'b1;
    push_ev(5, 1, 0, -1);
    drain(600, "press5");
    tick(33 * 45);
    check("keys_5_held", int'(keys), 'h0020);
    frame_sync();
    key_down[5] = 1'b0;
    push_ev(5, 0, 0, -1);
    drain(600, "release5");
`endif
    check("final_keys", int'(keys), 0);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
